lce_window_monitor: RTL and testbench
=====================================

Name: lce_window_monitor

Overview:
- Watches the stream of instructions accepted into the ID stage of the cv32e40p core.
- Detects linear code extraction: a run of WWDL consecutive accepted instructions whose PCs are strictly sequential, with no control-flow discontinuity.
- On detection it raises a sticky alarm_o, which the top-level bench samples to log the alarm cycle and PC and end simulation.
- Sits beside the IF/ID interface inside the core; it is purely observational and never stalls the pipeline.

Parameters:
- WWDL, 64: window length, the number of consecutive sequential instructions that triggers the alarm. Must be >= 2; elaboration error otherwise.
- CNT_W, $clog2(WWDL+1): width of the run counters (derived; do not override).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- enable_i  input  1  monitor enable.
- clear_i  input  1  synchronous clear of state, alarm and statistics.
- debug_mode_i  input  1  core is in debug mode; instructions are not counted.
- instr_valid_i  input  1  IF->ID instruction valid.
- instr_ready_i  input  1  ID accepts the instruction.
- pc_i  input  32  PC of the offered instruction.
- is_compressed_i  input  1  offered instruction is 16-bit.
- alarm_o  output  1  sticky linear-extraction alarm.
- alarm_pc_o  output  32  PC of the instruction that completed the window.
- run_len_o  output  CNT_W  current sequential run length.
- max_run_o  output  CNT_W  longest run since reset or clear.

Behaviour:
- Reset (async, rst_ni=0):
  - State = IDLE.
  - alarm_o=0, alarm_pc_o=0, run_len_o=0, max_run_o=0.
  - prev_pc=0, prev_len=0.
- Accepted instruction: fire = instr_valid_i & instr_ready_i & enable_i & ~debug_mode_i. Valid without ready is never counted (stall).
- Instruction size: len = 2 if is_compressed_i, else 4.
- Sequential test: pc_i == prev_pc + prev_len, computed modulo 2^32, so 0xFFFFFFFC -> 0x00000000 is sequential.
- State machine (IDLE, TRACK, ALARM), all updates registered on the clock edge:
  - IDLE, on fire: run_len=1, prev_pc=pc_i, prev_len=len, go to TRACK.
  - TRACK, on fire: run_len = sequential ? run_len+1 : 1; update prev_pc and prev_len.
  - TRACK, when the new run_len equals WWDL: alarm_o=1, alarm_pc_o=pc_i, go to ALARM.
  - ALARM: sticky. Fires are ignored and all outputs are held. Exit only via clear_i or reset.
  - TRACK with enable_i=0 or debug_mode_i=1 in a cycle: treated as a discontinuity. Go to IDLE, run_len=0; max_run_o is kept.
- Latency: alarm_o is high in the cycle after the clock edge that sampled the WWDL-th sequential fire.
- max_run_o:
  - Updated in the same edge as run_len, as max(max_run_o, new run_len).
  - Never exceeds WWDL. run_len also cannot exceed WWDL, because reaching it forces ALARM.
- clear_i:
  - Has priority over fire in any state.
  - Next state IDLE; alarm_o, alarm_pc_o, run_len_o and max_run_o all go to 0.
  - A fire in the same cycle as clear_i is discarded.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- No backpressure: the block has no outputs toward the pipeline.

Test Plan:
1. WWDL=8, eight back-to-back fires at PC 0x80, 0x84, ... 0x9C -> alarm_o=1 one cycle after the 8th fire, alarm_pc_o=0x9C, run_len_o=8, max_run_o=8. Further fires change nothing.
2. WWDL=8, seven sequential fires from 0x80, then 0x200, then 0x204..0x214 -> run_len_o=1 after 0x200 and 6 after 0x214. max_run_o=7, alarm_o=0.
3. Compressed mix: 0x80(c), 0x82, 0x86(c), 0x88 -> run_len_o=4. Then 0x88 as a 4-byte instruction followed by 0x8A -> run_len_o resets to 1.
4. Wrap-around: fires at 0xFFFFFFF8 and 0xFFFFFFFC, then 0x00000000 -> run_len_o=3, no discontinuity.
5. Stall and gating:
   - valid=1, ready=0 for 5 cycles mid-run -> run_len_o unchanged.
   - debug_mode_i=1 for one cycle -> run_len_o=0, state IDLE; max_run_o is retained.
6. Clear and reset:
   - clear_i asserted in the same cycle as the 8th sequential fire -> alarm_o stays 0, all outputs 0.
   - rst_ni dropped mid-run (run_len_o=5) -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lce_window_monitor_if.sv
// Instruction-acceptance, control and status signals between the IF/ID stage
// and the linear-code-extraction window monitor.
interface lce_window_monitor_if #(
  parameter int WWDL  = 64,
  parameter int CNT_W = $clog2(WWDL + 1)
);
  logic             enable_i;
  logic             clear_i;
  logic             debug_mode_i;
  logic             instr_valid_i;
  logic             instr_ready_i;
  logic [31:0]      pc_i;
  logic             is_compressed_i;
  logic             alarm_o;
  logic [31:0]      alarm_pc_o;
  logic [CNT_W-1:0] run_len_o;
  logic [CNT_W-1:0] max_run_o;

  // Pipeline / bench side: drives the observed instruction stream.
  modport master (
    output enable_i, clear_i, debug_mode_i, instr_valid_i, instr_ready_i,
           pc_i, is_compressed_i,
    input  alarm_o, alarm_pc_o, run_len_o, max_run_o
  );

  // Monitor side.
  modport slave (
    input  enable_i, clear_i, debug_mode_i, instr_valid_i, instr_ready_i,
           pc_i, is_compressed_i,
    output alarm_o, alarm_pc_o, run_len_o, max_run_o
  );
endinterface

// File: rtl/lce_window_monitor.sv
// Linear code extraction monitor: raises a sticky alarm once WWDL consecutive
// accepted instructions have strictly sequential PCs. Purely observational.
module lce_window_monitor #(
  parameter int WWDL  = 64,
  parameter int CNT_W = $clog2(WWDL + 1)
) (
  input logic                clk_i,
  input logic                rst_ni,
  lce_window_monitor_if.slave bus
);

  if (WWDL < 2) begin : g_bad_wwdl
    $error("lce_window_monitor: WWDL must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, TRACK, ALARM} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] run_len, run_len_nxt;
  logic [CNT_W-1:0] max_run, max_run_nxt;
  logic             alarm, alarm_nxt;
  logic [31:0]      alarm_pc, alarm_pc_nxt;
  logic [31:0]      prev_pc, prev_pc_nxt;
  logic [2:0]       prev_len, prev_len_nxt;

  logic             fire;
  logic             gated;
  logic             sequential;
  logic [2:0]       len;
  logic [CNT_W-1:0] run_new;

  assign gated      = ~bus.enable_i | bus.debug_mode_i;
  assign fire       = bus.instr_valid_i & bus.instr_ready_i & ~gated;
  assign len        = bus.is_compressed_i ? 3'd2 : 3'd4;
  // Modulo-2^32 add: 0xFFFFFFFC followed by 0x00000000 counts as sequential.
  assign sequential = (bus.pc_i == prev_pc + {29'd0, prev_len});

  // Next-state and next-output computation for the IDLE/TRACK/ALARM machine.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    run_len_nxt  = run_len;
    max_run_nxt  = max_run;
    alarm_nxt    = alarm;
    alarm_pc_nxt = alarm_pc;
    prev_pc_nxt  = prev_pc;
    prev_len_nxt = prev_len;
    run_new      = CNT_W'(1);

    if (bus.clear_i) begin
      // Clear wins over a simultaneous fire; that fire is dropped.
      state_nxt    = IDLE;
      run_len_nxt  = '0;
      max_run_nxt  = '0;
      alarm_nxt    = 1'b0;
      alarm_pc_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fire) begin
            state_nxt    = TRACK;
            run_len_nxt  = CNT_W'(1);
            prev_pc_nxt  = bus.pc_i;
            prev_len_nxt = len;
            if (max_run < CNT_W'(1)) max_run_nxt = CNT_W'(1);
          end
        end
        TRACK: begin
          if (gated) begin
            // Disabled or debug cycle breaks the run; the record is kept.
            state_nxt   = IDLE;
            run_len_nxt = '0;
          end else if (fire) begin
            // run_len < WWDL here, so the increment cannot overflow.
            run_new      = sequential ? run_len + CNT_W'(1) : CNT_W'(1);
            run_len_nxt  = run_new;
            prev_pc_nxt  = bus.pc_i;
            prev_len_nxt = len;
            if (run_new > max_run) max_run_nxt = run_new;
            if (run_new == CNT_W'(WWDL)) begin
              state_nxt    = ALARM;
              alarm_nxt    = 1'b1;
              alarm_pc_nxt = bus.pc_i;
            end
          end
        end
        ALARM: begin
          // Sticky: everything held until clear or reset.
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      run_len  <= '0;
      max_run  <= '0;
      alarm    <= 1'b0;
      alarm_pc <= '0;
      prev_pc  <= '0;
      prev_len <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state    <= state_nxt;
      run_len  <= run_len_nxt;
      max_run  <= max_run_nxt;
      alarm    <= alarm_nxt;
      alarm_pc <= alarm_pc_nxt;
      prev_pc  <= prev_pc_nxt;
      prev_len <= prev_len_nxt;
    end
  end

  assign bus.alarm_o    = alarm;
  assign bus.alarm_pc_o = alarm_pc;
  assign bus.run_len_o  = run_len;
  assign bus.max_run_o  = max_run;

endmodule

// File: tb/tb_lce_window_monitor.sv
// Self-checking bench for lce_window_monitor with WWDL=8: table of per-cycle
// vectors with hand-computed expectations fed through a scoreboard queue, plus
// hand-written reset sequences.
module tb_lce_window_monitor;

  localparam int WWDL  = 8;
  localparam int CNT_W = $clog2(WWDL + 1);

  typedef struct {
    logic             clr, dbg, en, vld, rdy, cmp;
    logic [31:0]      pc;
    logic             alarm;
    logic [31:0]      apc;
    logic [CNT_W-1:0] run, mx;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  vec_t vecs[$];
  vec_t sb[$];

  lce_window_monitor_if #(.WWDL(WWDL)) bus ();

  lce_window_monitor #(.WWDL(WWDL)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic al, input logic [31:0] apc,
                            input int run, input int mx);
    check({tag, " alarm"},    32'(bus.alarm_o),    32'(al));
    check({tag, " alarm_pc"}, bus.alarm_pc_o,      apc);
    check({tag, " run_len"},  32'(bus.run_len_o),  32'(run));
    check({tag, " max_run"},  32'(bus.max_run_o),  32'(mx));
  endtask

  // Generic vector.
  function automatic void add(logic clr, logic dbg, logic en, logic vld, logic rdy,
                              logic cmp, logic [31:0] pc, logic al,
                              logic [31:0] apc, int run, int mx);
    vec_t v;
    v.clr = clr; v.dbg = dbg; v.en = en; v.vld = vld; v.rdy = rdy; v.cmp = cmp;
    v.pc = pc; v.alarm = al; v.apc = apc;
    v.run = CNT_W'(run); v.mx = CNT_W'(mx);
    vecs.push_back(v);
  endfunction

  // Plain accepted instruction, no alarm expected.
  function automatic void fire(logic [31:0] pc, logic cmp, int run, int mx);
    add(0, 0, 1, 1, 1, cmp, pc, 0, 32'h0, run, mx);
  endfunction

  // Clear pulse together with a fire that must be discarded.
  function automatic void clr_row();
    add(1, 0, 1, 1, 1, 0, 32'h1234, 0, 32'h0, 0, 0);
  endfunction

  task automatic drive(input vec_t v);
    bus.clear_i         = v.clr;
    bus.debug_mode_i    = v.dbg;
    bus.enable_i        = v.en;
    bus.instr_valid_i   = v.vld;
    bus.instr_ready_i   = v.rdy;
    bus.is_compressed_i = v.cmp;
    bus.pc_i            = v.pc;
  endtask

  task automatic idle_inputs();
    bus.clear_i = 0; bus.debug_mode_i = 0; bus.enable_i = 1;
    bus.instr_valid_i = 0; bus.instr_ready_i = 0;
    bus.is_compressed_i = 0; bus.pc_i = 32'h0;
  endtask

  task automatic step_fire(input logic [31:0] pc);
    bus.clear_i = 0; bus.debug_mode_i = 0; bus.enable_i = 1;
    bus.instr_valid_i = 1; bus.instr_ready_i = 1;
    bus.is_compressed_i = 0; bus.pc_i = pc;
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t e;

    // 1: eight sequential fires trigger the alarm; later fires change nothing.
    for (int i = 0; i < 7; i++) fire(32'h80 + 32'(4 * i), 0, i + 1, i + 1);
    add(0, 0, 1, 1, 1, 0, 32'h9C, 1, 32'h9C, 8, 8);
    add(0, 0, 1, 1, 1, 0, 32'hA0, 1, 32'h9C, 8, 8);
    add(0, 0, 1, 1, 1, 0, 32'h300, 1, 32'h9C, 8, 8);
    clr_row();
    // 2: seven sequential, a jump, then five more sequential.
    for (int i = 0; i < 7; i++) fire(32'h80 + 32'(4 * i), 0, i + 1, i + 1);
    fire(32'h200, 0, 1, 7);
    for (int i = 1; i <= 5; i++) fire(32'h200 + 32'(4 * i), 0, i + 1, 7);
    clr_row();
    // 3: compressed mix, then a break after a 4-byte instruction at 0x88.
    fire(32'h80, 1, 1, 1);
    fire(32'h82, 0, 2, 2);
    fire(32'h86, 1, 3, 3);
    fire(32'h88, 0, 4, 4);
    fire(32'h8A, 1, 1, 4);
    clr_row();
    // 4: wrap-around through address zero.
    fire(32'hFFFF_FFF8, 0, 1, 1);
    fire(32'hFFFF_FFFC, 0, 2, 2);
    fire(32'h0000_0000, 0, 3, 3);
    fire(32'h0000_0004, 0, 4, 4);
    // 5: stall cycles hold the run; debug and disable break it.
    for (int i = 0; i < 5; i++) add(0, 0, 1, 1, 0, 0, 32'h8, 0, 32'h0, 4, 4);
    fire(32'h8, 0, 5, 5);
    add(0, 1, 1, 1, 1, 0, 32'hC, 0, 32'h0, 0, 5);
    fire(32'h100, 0, 1, 5);
    fire(32'h104, 0, 2, 5);
    add(0, 0, 0, 1, 1, 0, 32'h108, 0, 32'h0, 0, 5);
    fire(32'h108, 0, 1, 5);
    clr_row();
    // 6a: clear in the same cycle as the would-be alarming fire.
    for (int i = 0; i < 7; i++) fire(32'h80 + 32'(4 * i), 0, i + 1, i + 1);
    add(1, 0, 1, 1, 1, 0, 32'h9C, 0, 32'h0, 0, 0);
    fire(32'hA0, 0, 1, 1);

    // Reset state.
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 0, 32'h0, 0, 0);
    rst_n = 1'b1;

    // Table through the scoreboard.
    foreach (vecs[i]) begin
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        check($sformatf("v%0d scoreboard empty", i), 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check_outs($sformatf("v%0d", i), e.alarm, e.apc, e.run, e.mx);
      end
    end
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    // 6b: asynchronous reset mid-run with run_len=5.
    bus.clear_i = 1; bus.instr_valid_i = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) step_fire(32'h400 + 32'(4 * i));
    check("pre-reset run_len", 32'(bus.run_len_o), 32'd5);
    check("pre-reset max_run", 32'(bus.max_run_o), 32'd5);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    check_outs("async reset", 0, 32'h0, 0, 0);
    #1 rst_n = 1'b1;
    // After reset the monitor restarts from IDLE.
    step_fire(32'h414);
    check_outs("post-reset fire", 0, 32'h0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
